// File: rtl/uart_tx_queue.sv
// uart_tx_queue: circular FIFO in front of a UART transmitter.
// Words written by a host are queued and handed to the transmitter one at a
// time. Each hand-off is a single-cycle send_request. The next word is not
// offered until the transmitter reports tx_done.
module uart_tx_queue #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_BITS-1:0]  wr_data,
    input  logic                  overflow_clr,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic                  send_request,
    output logic [DATA_BITS-1:0]  tx_data,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  sending
);

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_WAIT_DONE = 1'b1;

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    // Storage is deliberately left out of reset so it can map onto RAM.
    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  send_request_q, send_request_d;
    logic [DATA_BITS-1:0]  tx_data_q, tx_data_d;
    logic                  overflow_q, overflow_d;
    logic                  sending_q, sending_d;

    logic full_w;
    logic empty_w;
    logic wr_accept;
    logic pop;

    assign full_w  = (count_q == FULL_COUNT);
    assign empty_w = (count_q == '0);

    // A write is accepted only when the FIFO was not full before the edge, so
    // a pop in the same cycle never makes room for it.
    assign wr_accept = wr_en && !full_w;
    // Pops happen only on the IDLE->WAIT_DONE transition. Because this uses
    // the pre-edge count, a word written into an empty FIFO cannot bypass.
    assign pop = (state_q == ST_IDLE) && !empty_w && !tx_busy;

    // Next-state logic for pointers, count, overflow flag and handshake FSM.
    always_comb begin
        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        send_request_d = 1'b0;
        tx_data_d      = tx_data_q;
        overflow_d     = overflow_q;
        sending_d      = sending_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        case ({wr_accept, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase

        // Set has priority over clear so an overflow is never lost.
        if (wr_en && full_w) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // tx_done arriving here is stale and is ignored.
                if (pop) begin
                    tx_data_d      = mem[rd_ptr_q];
                    rd_ptr_d       = rd_ptr_q + PTR_ONE;
                    send_request_d = 1'b1;
                    sending_d      = 1'b1;
                    state_d        = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // tx_busy is not consulted; only tx_done ends the transfer.
                if (tx_done) begin
                    sending_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            send_request_q <= 1'b0;
            tx_data_q      <= '1;
            overflow_q     <= 1'b0;
            sending_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            send_request_q <= send_request_d;
            tx_data_q      <= tx_data_d;
            overflow_q     <= overflow_d;
            sending_q      <= sending_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign send_request = send_request_q;
    assign tx_data      = tx_data_q;
    assign fifo_full    = full_w;
    assign fifo_empty   = empty_w;
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;
    assign sending      = sending_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed testbench for uart_tx_queue (DATA_BITS=8, DEPTH=16).
module tb_uart_tx_queue;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       overflow_clr = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic       send_request;
    logic [7:0] tx_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       sending;

    int tests = 0;
    int fails = 0;

    uart_tx_queue #(.DATA_BITS(8), .DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .overflow_clr (overflow_clr),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .send_request (send_request),
        .tx_data      (tx_data),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .sending      (sending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Finish the transfer in progress, then expect the next word popped.
    task automatic xfer(input logic [7:0] exp);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        check("xfer_req", send_request, 1);
        check("xfer_data", tx_data, exp);
    endtask

    int         req_cnt;
    int         busy_cnt;
    logic [7:0] cur_exp;

    initial begin
        // Reset state
        step();
        step();
        check("rst_req", send_request, 0);
        check("rst_txdata", tx_data, 8'hFF);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_sending", sending, 0);
        reset = 1'b0;
        step();

        // Single write of 0xA5
        wr_en = 1'b1;
        wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        check("single_cnt1", fifo_count, 1);
        check("single_noreq", send_request, 0);
        step();
        check("single_req", send_request, 1);
        check("single_data", tx_data, 8'hA5);
        check("single_cnt0", fifo_count, 0);
        check("single_sending", sending, 1);
        step();
        check("single_req_off", send_request, 0);
        check("single_hold", tx_data, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            step();
            check("single_sending_hold", sending, 1);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("single_done", sending, 0);
        step();
        check("single_no_more", send_request, 0);

        // Burst of 16 words with a transmitter answering 20 cycles later
        req_cnt = 0;
        busy_cnt = 0;
        cur_exp = 8'h00;
        for (int c = 0; c < 450; c++) begin
            if (c < 16) begin
                wr_en = 1'b1;
                wr_data = 8'(c + 1);
            end else begin
                wr_en = 1'b0;
            end
            step();
            tx_done = 1'b0;
            if (send_request) begin
                req_cnt++;
                cur_exp = 8'(req_cnt);
                check("burst_data", tx_data, cur_exp);
                busy_cnt = 20;
                tx_busy = 1'b1;
            end else if (busy_cnt > 0) begin
                check("burst_hold", tx_data, cur_exp);
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_done = 1'b1;
                    tx_busy = 1'b0;
                end
            end
        end
        tx_done = 1'b0;
        wr_en = 1'b0;
        check("burst_reqs", req_cnt, 16);
        check("burst_ovf", overflow, 0);
        check("burst_empty", fifo_count, 0);

        // Fill with transmitter busy, then overflow
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h20 + i);
            step();
        end
        wr_en = 1'b0;
        check("fill_cnt", fifo_count, 16);
        check("fill_full", fifo_full, 1);
        check("fill_ovf0", overflow, 0);
        wr_en = 1'b1;
        wr_data = 8'h50;
        step();
        wr_en = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_cnt", fifo_count, 16);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("ovf_clr", overflow, 0);
        check("ovf_clr_cnt", fifo_count, 16);
        overflow_clr = 1'b1;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        check("ovf_set_wins", overflow, 1);
        step();
        overflow_clr = 1'b0;
        check("ovf_clr2", overflow, 0);

        // Write while full coinciding with a pop
        wr_en = 1'b1;
        wr_data = 8'h99;
        tx_busy = 1'b0;
        step();
        wr_en = 1'b0;
        check("fullpop_req", send_request, 1);
        check("fullpop_data", tx_data, 8'h20);
        check("fullpop_cnt", fifo_count, 15);
        check("fullpop_ovf", overflow, 1);

        // Drain to three words, then write and pop together
        for (int i = 0; i < 12; i++) begin
            xfer(8'(8'h21 + i));
        end
        check("drain_cnt3", fifo_count, 3);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'h30;
        step();
        wr_en = 1'b0;
        check("wrpop_req", send_request, 1);
        check("wrpop_data", tx_data, 8'h2D);
        check("wrpop_cnt", fifo_count, 3);
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h31 + i);
            step();
        end
        wr_en = 1'b0;
        check("wrap_cnt", fifo_count, 13);
        xfer(8'h2E);
        xfer(8'h2F);
        for (int i = 0; i < 11; i++) begin
            xfer(8'(8'h30 + i));
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("wrap_sending", sending, 0);
        check("wrap_empty", fifo_empty, 1);
        step();
        check("wrap_noreq", send_request, 0);

        // Reset while waiting for tx_done with five words queued
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h40 + i);
            step();
        end
        wr_en = 1'b0;
        check("pre_rst_cnt", fifo_count, 5);
        check("pre_rst_sending", sending, 1);
        reset = 1'b1;
        #2;
        check("arst_req", send_request, 0);
        check("arst_sending", sending, 0);
        check("arst_cnt", fifo_count, 0);
        check("arst_empty", fifo_empty, 1);
        check("arst_txdata", tx_data, 8'hFF);
        check("arst_ovf", overflow, 0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_rst_noreq", send_request, 0);
        end
        wr_en = 1'b1;
        wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        step();
        check("post_rst_req", send_request, 1);
        check("post_rst_data", tx_data, 8'h77);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
